// File: rtl/hazard_pkg.sv
`default_nettype none
// hazard_pkg: scoreboard slot type and forwarding-select helpers shared by the hazard unit.
package hazard_pkg;

  // Widest register index a slot can hold; the unit's REG_IDX_W must not exceed it.
  localparam int unsigned HZ_IDX_W = 5;

  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic                reg_wr;
    logic [HZ_IDX_W-1:0] rd;
    logic                is_load;
  } hz_slot_t;

  // Select width: value 0 is the register file, values 1..depth pick a slot.
  function automatic int unsigned fwd_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_check.sv
`default_nettype none
// hazard_src_check: priority search of the scoreboard for one source operand.
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int unsigned REG_IDX_W  = HZ_IDX_W,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_AVAIL = 1,
  parameter int unsigned FWD_W      = fwd_width(DEPTH)
) (
  input  hz_slot_t [DEPTH-1:0]     slots_i,
  input  logic [REG_IDX_W-1:0]     rs_i,
  input  logic                     rs_used_i,
  output logic [FWD_W-1:0]         sel_o,
  output logic                     hazard_o
);

  // Walk oldest to youngest so the youngest matching slot is the last writer.
  always_comb begin
    sel_o    = FWD_W'(FWD_REGFILE);
    hazard_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots_i[k].valid && slots_i[k].reg_wr && rs_used_i &&
          (rs_i != '0) && (slots_i[k].rd == HZ_IDX_W'(rs_i))) begin
        if (slots_i[k].is_load && (k < int'(LOAD_AVAIL))) begin
          hazard_o = 1'b1;
          sel_o    = FWD_W'(FWD_REGFILE);
        end else begin
          hazard_o = 1'b0;
          sel_o    = FWD_W'(k + 1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// hazard_unit: in-flight write scoreboard driving forwarding selects, load-use stalls,
// branch flushes and external-stall freezes, with saturating stall/flush counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_IDX_W  = HZ_IDX_W,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_AVAIL = 1,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned FWD_W     = fwd_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [REG_IDX_W-1:0] id_rd_i,
  input  logic                 id_reg_wr_i,
  input  logic                 id_rd_mem_i,
  input  logic                 ex_take_branch_i,
  input  logic                 ext_stall_i,
  output logic                 stall_id_o,
  output logic                 flush_o,
  output logic [FWD_W-1:0]     fwd_a_sel_o,
  output logic [FWD_W-1:0]     fwd_b_sel_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  hz_slot_t [DEPTH-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]     stall_cnt_q, flush_cnt_q;
  logic [FWD_W-1:0]     sel_a, sel_b;
  logic                 haz_a, haz_b;
  logic                 load_use, flush, stall;

  hazard_src_check #(
    .REG_IDX_W (REG_IDX_W),
    .DEPTH     (DEPTH),
    .LOAD_AVAIL(LOAD_AVAIL),
    .FWD_W     (FWD_W)
  ) u_chk_rs1 (
    .slots_i  (slot_q),
    .rs_i     (id_rs1_i),
    .rs_used_i(id_rs1_used_i),
    .sel_o    (sel_a),
    .hazard_o (haz_a)
  );

  hazard_src_check #(
    .REG_IDX_W (REG_IDX_W),
    .DEPTH     (DEPTH),
    .LOAD_AVAIL(LOAD_AVAIL),
    .FWD_W     (FWD_W)
  ) u_chk_rs2 (
    .slots_i  (slot_q),
    .rs_i     (id_rs2_i),
    .rs_used_i(id_rs2_used_i),
    .sel_o    (sel_b),
    .hazard_o (haz_b)
  );

  // A branch waits in EX while frozen, so the flush is simply deferred.
  assign load_use = id_valid_i & (haz_a | haz_b);
  assign flush    = ex_take_branch_i & ~ext_stall_i;
  assign stall    = ext_stall_i | (load_use & ~flush);

  assign stall_id_o  = rst & stall;
  assign flush_o     = rst & flush;
  assign fwd_a_sel_o = rst ? sel_a : '0;
  assign fwd_b_sel_o = rst ? sel_b : '0;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    slot_d = slot_q;
    if (!ext_stall_i) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        slot_d[i] = slot_q[i-1];
      end
      if (flush || load_use) begin
        slot_d[0] = '0;
      end else begin
        slot_d[0].valid   = id_valid_i;
        slot_d[0].reg_wr  = id_reg_wr_i & id_valid_i;
        slot_d[0].rd      = HZ_IDX_W'(id_rd_i);
        slot_d[0].is_load = id_rd_mem_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// tb_hazard_unit: directed scenarios for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_rd_mem;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_take_branch, ext_stall;

  logic        stall_id, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

  logic        stall_id4, flush4;
  logic [1:0]  fwd_a_sel4, fwd_b_sel4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_reg_wr_i(id_reg_wr), .id_rd_mem_i(id_rd_mem),
    .ex_take_branch_i(ex_take_branch), .ext_stall_i(ext_stall),
    .stall_id_o(stall_id), .flush_o(flush),
    .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_reg_wr_i(id_reg_wr), .id_rd_mem_i(id_rd_mem),
    .ex_take_branch_i(ex_take_branch), .ext_stall_i(ext_stall),
    .stall_id_o(stall_id4), .flush_o(flush4),
    .fwd_a_sel_o(fwd_a_sel4), .fwd_b_sel_o(fwd_b_sel4),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_reg_wr = 0; id_rd_mem = 0; ex_take_branch = 0; ext_stall = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_wr = wr; id_rd_mem = ld;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 0;
    ex_take_branch = 1; ext_stall = 1;
    set_id(1, 5, 1, 6, 1, 7, 1, 1);
    settle();
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_id); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0d exp 0", flush); end
    checks++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d exp 0/0", fwd_a_sel, fwd_b_sel); end
    tick();
    clear_in();
    rst = 1;
    settle();
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    checks++; if (stall_id !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rst_idle got %0d/%0d exp 0/0", stall_id, flush); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);          // add x5
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);          // add x6, x5
    settle();
    checks++; if (fwd_a_sel !== 2'd1) begin errors++; $display("FAIL b2b_ex got %0d exp 1", fwd_a_sel); end
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL b2b_nostall got %0d exp 0", stall_id); end
    tick();
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    settle();
    checks++; if (fwd_a_sel !== 2'd2) begin errors++; $display("FAIL b2b_mem got %0d exp 2", fwd_a_sel); end
    tick();
    set_id(1, 5, 1, 6, 1, 0, 0, 0);
    settle();
    checks++; if (fwd_a_sel !== 2'd3) begin errors++; $display("FAIL b2b_wb got %0d exp 3", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'd2) begin errors++; $display("FAIL b2b_rs2 got %0d exp 2", fwd_b_sel); end
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);          // add x5
    tick();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);          // add x5 again
    tick();
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    settle();
    checks++; if (fwd_a_sel !== 2'd1) begin errors++; $display("FAIL prio_youngest got %0d exp 1", fwd_a_sel); end
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);          // add x5
    tick();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);          // lw x5
    tick();
    set_id(1, 5, 1, 0, 0, 0, 0, 0);
    settle();
    checks++; if (stall_id !== 1'b1 || fwd_a_sel !== 2'd0) begin errors++; $display("FAIL prio_load got stall %0d sel %0d exp 1/0", stall_id, fwd_a_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);          // lw x7
    tick();
    set_id(1, 0, 0, 7, 1, 8, 1, 0);          // add x8, x0, x7
    settle();
    checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d exp 1", stall_id); end
    checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("FAIL lu_sel0 got %0d exp 0", fwd_b_sel); end
    tick();
    settle();
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_release got %0d exp 0", stall_id); end
    checks++; if (fwd_b_sel !== 2'd2) begin errors++; $display("FAIL lu_fwd_mem got %0d exp 2", fwd_b_sel); end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
    tick();
    clear_in();
    settle();
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_id(1, 0, 0, 0, 0, 9, 1, 0);          // add x9 in ID, killed by branch
    ex_take_branch = 1;
    settle();
    checks++; if (flush !== 1'b1 || stall_id !== 1'b0) begin errors++; $display("FAIL br_flush got %0d/%0d exp 1/0", flush, stall_id); end
    tick();
    ex_take_branch = 0;
    set_id(1, 9, 1, 0, 0, 0, 0, 0);
    settle();
    checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL br_bubble got %0d exp 0", fwd_a_sel); end
    checks++; if (flush !== 1'b0 || flush_cnt !== 32'd1) begin errors++; $display("FAIL br_cnt got flush %0d cnt %0d exp 0/1", flush, flush_cnt); end
    do_reset();
    set_id(1, 0, 0, 0, 0, 4, 1, 1);          // lw x4
    tick();
    set_id(1, 4, 1, 0, 0, 0, 0, 0);
    ex_take_branch = 1;
    settle();
    checks++; if (flush !== 1'b1 || stall_id !== 1'b0) begin errors++; $display("FAIL br_over_lu got %0d/%0d exp 1/0", flush, stall_id); end
    tick();
    ex_take_branch = 0;
    settle();
    checks++; if (fwd_a_sel !== 2'd2 || stall_id !== 1'b0) begin errors++; $display("FAIL br_after_lu got sel %0d stall %0d exp 2/0", fwd_a_sel, stall_id); end
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(1, 0, 0, 0, 0, 10, 1, 0);         // add x10
    tick();
    set_id(1, 10, 1, 0, 0, 11, 1, 0);
    ext_stall = 1; ex_take_branch = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (flush !== 1'b0 || stall_id !== 1'b1) begin errors++; $display("FAIL frz_ctrl%0d got %0d/%0d exp 0/1", i, flush, stall_id); end
      checks++; if (fwd_a_sel !== 2'd1) begin errors++; $display("FAIL frz_sb%0d got %0d exp 1", i, fwd_a_sel); end
      tick();
    end
    ext_stall = 0;
    settle();
    checks++; if (flush !== 1'b1 || stall_id !== 1'b0) begin errors++; $display("FAIL frz_release got %0d/%0d exp 1/0", flush, stall_id); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL frz_cnt got %0d exp 3", stall_cnt); end
    tick();
    clear_in();
    settle();
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL frz_fcnt got %0d exp 1", flush_cnt); end
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 1);          // lw x3
    tick();
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    ext_stall = 1;
    tick();
    ext_stall = 0;
    settle();
    checks++; if (stall_id !== 1'b1 || stall_cnt !== 32'd1) begin errors++; $display("FAIL frz_lu got stall %0d cnt %0d exp 1/1", stall_id, stall_cnt); end
    tick();
    settle();
    checks++; if (stall_id !== 1'b0 || fwd_a_sel !== 2'd2 || stall_cnt !== 32'd2) begin errors++; $display("FAIL frz_lu_done got stall %0d sel %0d cnt %0d exp 0/2/2", stall_id, fwd_a_sel, stall_cnt); end
  endtask

  task automatic test_x0_unused();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);          // load to x0
    tick();
    set_id(1, 0, 1, 0, 1, 0, 0, 0);
    settle();
    checks++; if (fwd_a_sel !== 2'd0 || stall_id !== 1'b0) begin errors++; $display("FAIL x0 got sel %0d stall %0d exp 0/0", fwd_a_sel, stall_id); end
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 1);          // lw x3
    tick();
    set_id(1, 3, 0, 0, 0, 0, 0, 0);
    settle();
    checks++; if (stall_id !== 1'b0 || fwd_a_sel !== 2'd0) begin errors++; $display("FAIL unused got stall %0d sel %0d exp 0/0", stall_id, fwd_a_sel); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);          // lw x7
    tick();
    set_id(1, 0, 0, 7, 1, 8, 1, 0);
    settle();
    checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL rms_pre got %0d exp 1", stall_id); end
    rst = 0;
    settle();
    checks++; if (stall_id !== 1'b0 || flush !== 1'b0 || fwd_b_sel !== 2'd0) begin errors++; $display("FAIL rms_gated got %0d/%0d/%0d exp 0/0/0", stall_id, flush, fwd_b_sel); end
    tick();
    rst = 1;
    settle();
    checks++; if (stall_id !== 1'b0 || fwd_b_sel !== 2'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL rms_empty got %0d/%0d/%0d exp 0/0/0", stall_id, fwd_b_sel, stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    ext_stall = 1;
    for (int i = 0; i < 20; i++) tick();
    ext_stall = 0;
    settle();
    checks++; if (stall_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide got %0d exp 20", stall_cnt); end
    checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_narrow got %0d exp 15", stall_cnt4); end
  endtask

  initial begin
    clear_in();
    rst = 0;
    tick();
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_branch_flush();
    test_freeze();
    test_x0_unused();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard-detection and forwarding controller for the in-order RISC-V pipeline. It holds a DEPTH-entry scoreboard of in-flight register writes, one entry per stage from EX to WB. From it the block computes operand-forwarding selects for the instruction in ID, load-use stalls, branch flushes and external-stall freezes. It sits beside the ID stage, drives the IF/ID and ID/EX register enables and kills, and keeps saturating performance counters for stall and flush cycles.

## Interface
Parameters:
- REG_IDX_W, 5: architectural register index width; register 0 is never tracked.
- DEPTH, 3: scoreboard slots; slot 0 = EX, slot DEPTH-1 = WB.
- LOAD_AVAIL, 1: first slot index at which load data can be forwarded.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  REG_IDX_W  source indices of the ID instruction
- id_rs1_used, id_rs2_used  in  1  source is actually read
- id_rd  in  REG_IDX_W  destination of the ID instruction
- id_reg_wr  in  1  ID instruction writes id_rd
- id_rd_mem  in  1  ID instruction is a load
- ex_take_branch  in  1  EX resolved a taken branch or jump
- ext_stall  in  1  memory not ready; freeze the whole pipeline
- stall_id  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- flush  out  1  kill IF/ID and ID/EX contents
- fwd_a_sel, fwd_b_sel  out  FWD_W = $clog2(DEPTH+1)  0 = register file, k = result of slot k-1
- stall_cnt, flush_cnt  out  CNT_W  saturating cycle counters

## Operation
- Slot fields: valid, reg_wr, rd, is_load.
- A slot matches source rs when all hold: valid, reg_wr, rd == rs, rs != 0, and rsX_used.
- Per source, the match is taken from the youngest (lowest-index) matching slot k:
  - If no slot matches, sel = 0.
  - If the matching slot is a load with k < LOAD_AVAIL, it is a load-use hazard; sel = 0.
  - Otherwise sel = k+1.
- load_use = id_valid & (hazard on rs1 | hazard on rs2).
- Control outputs:
  - flush = ex_take_branch & !ext_stall.
  - stall_id = ext_stall | (load_use & !flush). Flush overrides load-use.
- Scoreboard update at each posedge:
  - ext_stall = 1: no change (freeze).
  - flush = 1: shift; slot 0 <= bubble (valid = 0).
  - load_use = 1: shift; slot 0 <= bubble.
  - otherwise: shift; slot 0 <= {id_valid, id_reg_wr & id_valid, id_rd, id_rd_mem}.
  - Shift means slot i <= slot i-1. The old slot DEPTH-1 retires.
- Counters:
  - stall_cnt increments on every cycle with stall_id = 1.
  - flush_cnt increments on every cycle with flush = 1.
  - Both saturate at all-ones with no wrap.
- Writes with id_rd = 0 are stored, but they never match.

## Timing
- All outputs are combinational from the registered scoreboard plus the current ID/EX inputs; there is no added latency.
- The scoreboard advances one slot per unfrozen cycle.
- A load followed immediately by a dependent instruction costs exactly LOAD_AVAIL stall cycles. With the default, that is 1 stall, then the source is forwarded with sel = 2 (MEM).
- A taken branch costs one flush cycle. That cycle kills the two younger instructions, which sit in IF/ID and ID.
- Reset (rst = 0 at posedge):
  - All slots invalid; counters 0.
  - While rst = 0, stall_id = 0, flush = 0, fwd_a_sel = fwd_b_sel = 0 regardless of inputs.
  - Reset mid-stall discards all pending hazards.
- Simultaneous events:
  - ext_stall & ex_take_branch: flush is deferred until ext_stall drops. The branch is held in EX, so nothing is lost.
  - ext_stall & load_use: one stall cycle counted; the scoreboard stays frozen.

## Structure
- hazard_pkg holds:
  - the slot struct typedef hz_slot_t {valid, reg_wr, rd, is_load};
  - FWD_W as a localparam function;
  - the FWD_REGFILE = 0 constant.
- Sub-module hazard_src_check: combinational priority search over the slots for one source. It returns sel and hazard, and is instantiated twice (rs1, rs2).
- The top level holds the slot shift register, the control equations and the counters.

## Test plan
- Back-to-back ALU: add x5 in ID, then a dependent add with id_rs1 = 5. Required: fwd_a_sel = 1, stall_id = 0. After two more cycles with no new match, fwd_a_sel = 3 (WB).
- Load-use: lw x7, then ID reads rs2 = 7. Required: stall_id = 1 for 1 cycle and stall_cnt = 1, then fwd_b_sel = 2 with no further stall.
- Branch flush: ex_take_branch = 1 with ext_stall = 0. Required: flush = 1 for 1 cycle, slot 0 is a bubble next cycle, flush_cnt = 1.
- Freeze: ext_stall = 1 for 3 cycles with ex_take_branch = 1. Required: flush = 0 and scoreboard unchanged for those cycles, stall_cnt += 3. When ext_stall drops, flush = 1.
- x0 and unused sources:
  - A pending write to x0 with ID rs1 = 0 gives sel = 0 and no stall.
  - A pending load to x3 with id_rs1 = 3 but id_rs1_used = 0 gives no stall.
- Reset and saturation:
  - rst = 0 mid load-use gives all outputs 0 and an empty scoreboard the next cycle.
  - With CNT_W = 4, 20 stall cycles give stall_cnt = 15.
